fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the ID-stage forwarding/stall controller.
- Tracks destination tags of in-flight instructions in a configurable-depth tag pipeline behind ID.
- Produces per-operand forwarding selects, a load-use/late-result stall and bubble injection.
- Adds a multi-cycle EX operation (mul/div) with its own busy FSM. The datapath uses FWDA/FWDB to pick a stage result; the decoder uses STALL to hold PC/IR.

Parameters:
- AW, 5, register address width.
- STAGES, 3, number of tracked stages after ID (1 = EX output, 2 = MEM output, ...). Must be >= 2.
- LD_READY, 2, first stage index at which load data is forwardable. Range 1..STAGES.
- MD_LAT, 4, EX occupancy in cycles of a multi-cycle op. Must be >= 1.
- FWD_W, $clog2(STAGES+1), derived select width. Not to be overridden.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active high
- ID_VALID  in  1  ID holds a live instruction
- ID_RS  in  AW  source A register
- ID_RT  in  AW  source B register
- ID_USE_RS  in  1  instruction reads RS
- ID_USE_RT  in  1  instruction reads RT
- ID_DES  in  AW  destination register
- ID_WREG  in  1  instruction writes ID_DES
- ID_M2REG  in  1  instruction is a load
- ID_MD  in  1  instruction is multi-cycle
- FLUSH  in  1  kill ID instruction this cycle
- STALL  out  1  hold PC and IF/ID register
- BUBBLE  out  1  hazard bubble inserted into EX this cycle
- FWDA  out  FWD_W  source A select: 0 = register file, k = stage k result
- FWDB  out  FWD_W  source B select, same encoding as FWDA
- MD_BUSY  out  1  EX occupied by a multi-cycle op

Behaviour:
- Tag entry T[k], k = 1..STAGES: {V, DES, LD, MD, DONE}.
- Reset (async, any time, including mid-MD): all V=0, FSM IDLE, MD counter 0. STALL, BUBBLE, FWDA, FWDB and MD_BUSY are 0 while RST is high and in the first cycle after if ID_VALID=0.
- Issue qualifier: ISS = ID_VALID & ~FLUSH.
- Effective write: ID_WREG & (ID_DES != 0). Register 0 is never tagged, never matched, never forwarded.
- Match for source s (USE=1, s != 0): smallest k with T[k].V & T[k].DES == s. The youngest producer wins.
- Ready of T[k]:
  - not LD, not MD: ready at any k.
  - LD: ready iff k >= LD_READY.
  - MD: ready iff DONE.
- FWDx = k if the match is ready. FWDx = 0 if there is no match, USE=0, s=0, or the match is not ready.
- HAZ = ISS & (a matched source is not ready).
- FSM IDLE:
  - If ISS & ~HAZ & ID_MD & MD_LAT > 1: load T[1] with DONE=0, counter = MD_LAT-1, go BUSY.
  - Otherwise a normal shift.
- FSM BUSY:
  - MD_BUSY=1 and STALL=1.
  - T[1] is held; T[2..] shift and T[2] receives V=0.
  - Counter decrements each cycle. In the cycle it reaches 0, set T[1].DONE=1 and go IDLE.
  - The next cycle, T[1] shifts normally.
  - The ID instruction is not issued while BUSY. Forwarding outputs still evaluate combinationally.
- Normal shift: T[k+1] <= T[k]; T[STAGES] retires. The register file must be write-before-read.
  - ISS & ~HAZ: T[1] <= {1, ID_DES, ID_M2REG, ID_MD, MD_LAT == 1}, V=0 if not an effective write.
  - HAZ: T[1] <= bubble, STALL=1, BUBBLE=1.
  - ~ISS: T[1] <= bubble, STALL=0.
- STALL = HAZ | MD_BUSY. BUBBLE = HAZ & ~MD_BUSY.
- FLUSH has priority over HAZ: a killed instruction never stalls. FLUSH does not abort a BUSY MD op.
- Outputs are combinational from the registered tags and the ID inputs. There is no added latency.

Test Plan:
- Default params: `add r3` then `add r4,r3,r1` → FWDA=1, FWDB=0, STALL=0. Next instruction reading r3 → FWDA=2. Fourth instruction → FWDA=3. Fifth → FWDA=0.
- `lw r5` then `add r6,r5,r5` → cycle 1: STALL=1, BUBBLE=1, FWDA=FWDB=0. Cycle 2: STALL=0, FWDA=FWDB=2.
- Back-to-back `add r7` and `or r7` then reader of r7 → FWDA=1 (youngest). Reader of r0 with T holding DES=0 → FWDA=0.
- MD_LAT=4: `mul r9` then reader of r9 → MD_BUSY=1 and STALL=1 for 3 cycles. Next cycle: MD_BUSY=0 and FWDA=1.
- RST asserted during the 2nd MD busy cycle → MD_BUSY, STALL and all FWD go to 0 immediately. After release, reader of r9 → FWDA=0.
- STAGES=4, LD_READY=3: load-use → STALL=1 for 2 cycles, then FWDA=3. The same case with FLUSH=1 in the first cycle → STALL=0 and the T[1] bubble.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding/stall controller: tracks in-flight destination tags behind ID
// and resolves per-operand forwarding, load-use/late-result stalls and a multi-cycle EX op.
module fwd_hazard_unit #(
    parameter int AW       = 5,
    parameter int STAGES   = 3,
    parameter int LD_READY = 2,
    parameter int MD_LAT   = 4,
    parameter int FWD_W    = $clog2(STAGES + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_VALID,
    input  logic [AW-1:0]    ID_RS,
    input  logic [AW-1:0]    ID_RT,
    input  logic             ID_USE_RS,
    input  logic             ID_USE_RT,
    input  logic [AW-1:0]    ID_DES,
    input  logic             ID_WREG,
    input  logic             ID_M2REG,
    input  logic             ID_MD,
    input  logic             FLUSH,
    output logic             STALL,
    output logic             BUBBLE,
    output logic [FWD_W-1:0] FWDA,
    output logic [FWD_W-1:0] FWDB,
    output logic             MD_BUSY
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] des;
        logic          ld;
        logic          md;
        logic          done;
    } tag_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    tag_t          tags [1:STAGES];
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [STAGES:1] rdy, hit_a, hit_b;
    logic          nr_a, nr_b;
    logic          iss, haz, md_busy, issue, start_md;
    tag_t          new_tag;

    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            if (tags[k].md)
                rdy[k] = tags[k].done;
            else if (tags[k].ld)
                rdy[k] = (k >= LD_READY);
            else
                rdy[k] = 1'b1;
            hit_a[k] = ID_USE_RS && (ID_RS != '0) && tags[k].v && (tags[k].des == ID_RS);
            hit_b[k] = ID_USE_RT && (ID_RT != '0) && tags[k].v && (tags[k].des == ID_RT);
        end
    end

    // Scan oldest to youngest so the youngest producer (lowest k) has the final say.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        FWDA = '0;
        FWDB = '0;
        nr_a = 1'b0;
        nr_b = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hit_a[k]) begin
                FWDA = rdy[k] ? FWD_W'(k) : '0;
                nr_a = ~rdy[k];
            end
            if (hit_b[k]) begin
                FWDB = rdy[k] ? FWD_W'(k) : '0;
                nr_b = ~rdy[k];
            end
        end
    end

    always_comb begin
        iss      = ID_VALID & ~FLUSH;
        haz      = iss & (nr_a | nr_b);
        md_busy  = (state == S_BUSY);
        issue    = iss & ~haz & ~md_busy;
        start_md = issue & ID_MD & (MD_LAT > 1);
        STALL    = haz | md_busy;
        BUBBLE   = haz & ~md_busy;
        MD_BUSY  = md_busy;

        new_tag = '0;
        if (issue) begin
            new_tag.v    = ID_WREG & (ID_DES != '0);
            new_tag.des  = ID_DES;
            new_tag.ld   = ID_M2REG;
            new_tag.md   = ID_MD;
            new_tag.done = (MD_LAT == 1);
        end
    end

    // Counter runs MD_LAT-1 busy cycles; the op spends its last EX cycle back in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (start_md) begin
                    state_next = S_BUSY;
                    cnt_next   = CW'(MD_LAT - 1);
                end
            end
            S_BUSY: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the tag array is reset, unlike a data memory, because stale valid bits would forward garbage.
            for (int k = 1; k <= STAGES; k++)
                tags[k] <= '0;
        end else begin
            for (int k = STAGES; k >= 3; k--)
                tags[k] <= tags[k-1];
            if (md_busy) begin
                tags[2] <= '0;
                if (cnt == CW'(1))
                    tags[1].done <= 1'b1;
            end else begin
                tags[2] <= tags[1];
                tags[1] <= new_tag;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three parameter sets share one directed stimulus and are
// compared every cycle against a slot-list model, with literal expectations pinning both.
module tb_fwd_hazard_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ID_VALID, ID_USE_RS, ID_USE_RT, ID_WREG, ID_M2REG, ID_MD, FLUSH;
    logic [4:0] ID_RS, ID_RT, ID_DES;

    logic       stall0, bubble0, busy0, stall1, bubble1, busy1, stall2, bubble2, busy2;
    logic [1:0] fwda0, fwdb0, fwda2, fwdb2;
    logic [2:0] fwda1, fwdb1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fwd_hazard_unit #(.AW(5)) dut0 (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USE_RS(ID_USE_RS), .ID_USE_RT(ID_USE_RT), .ID_DES(ID_DES), .ID_WREG(ID_WREG),
        .ID_M2REG(ID_M2REG), .ID_MD(ID_MD), .FLUSH(FLUSH), .STALL(stall0), .BUBBLE(bubble0),
        .FWDA(fwda0), .FWDB(fwdb0), .MD_BUSY(busy0)
    );

    fwd_hazard_unit #(.AW(5), .STAGES(4), .LD_READY(3)) dut1 (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USE_RS(ID_USE_RS), .ID_USE_RT(ID_USE_RT), .ID_DES(ID_DES), .ID_WREG(ID_WREG),
        .ID_M2REG(ID_M2REG), .ID_MD(ID_MD), .FLUSH(FLUSH), .STALL(stall1), .BUBBLE(bubble1),
        .FWDA(fwda1), .FWDB(fwdb1), .MD_BUSY(busy1)
    );

    fwd_hazard_unit #(.AW(5), .STAGES(2), .LD_READY(1), .MD_LAT(1)) dut2 (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USE_RS(ID_USE_RS), .ID_USE_RT(ID_USE_RT), .ID_DES(ID_DES), .ID_WREG(ID_WREG),
        .ID_M2REG(ID_M2REG), .ID_MD(ID_MD), .FLUSH(FLUSH), .STALL(stall2), .BUBBLE(bubble2),
        .FWDA(fwda2), .FWDB(fwdb2), .MD_BUSY(busy2)
    );

    typedef struct {
        bit v;
        int des;
        bit ld;
        bit md;
        bit done;
    } slot_t;

    slot_t pipe [3][1:4];
    int    md_left [3];

    function automatic int cfg_s(input int c);
        return (c == 0) ? 3 : (c == 1) ? 4 : 2;
    endfunction

    function automatic int cfg_lr(input int c);
        return (c == 0) ? 2 : (c == 1) ? 3 : 1;
    endfunction

    function automatic int cfg_ml(input int c);
        return (c == 2) ? 1 : 4;
    endfunction

    function automatic slot_t empty_slot();
        slot_t e;
        e.v = 0; e.des = 0; e.ld = 0; e.md = 0; e.done = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_find(input int c, input bit use_s, input int s,
                                       output int sel, output bit not_ready);
        bit found = 0;
        bit r;
        sel = 0;
        not_ready = 0;
        if (use_s && s != 0) begin
            for (int k = 1; k <= cfg_s(c); k++) begin
                if (!found && pipe[c][k].v && pipe[c][k].des == s) begin
                    found = 1;
                    if (pipe[c][k].md)      r = pipe[c][k].done;
                    else if (pipe[c][k].ld) r = (k >= cfg_lr(c));
                    else                    r = 1;
                    sel = r ? k : 0;
                    not_ready = !r;
                end
            end
        end
    endfunction

    function automatic void model_eval(input int c, output logic [31:0] st, bu, mb, fa, fb,
                                       output bit ok);
        int sa, sb;
        bit na, nb, iss, haz, busy;
        iss = ID_VALID && !FLUSH;
        model_find(c, ID_USE_RS, int'(ID_RS), sa, na);
        model_find(c, ID_USE_RT, int'(ID_RT), sb, nb);
        haz  = iss && (na || nb);
        busy = md_left[c] > 0;
        st = 32'(haz || busy);
        bu = 32'(haz && !busy);
        mb = 32'(busy);
        fa = 32'(sa);
        fb = 32'(sb);
        ok = iss && !haz && !busy;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            md_left[c] = 0;
            for (int k = 1; k <= 4; k++) pipe[c][k] = empty_slot();
        end
    endtask

    task automatic model_step(input int c);
        logic [31:0] st, bu, mb, fa, fb;
        bit ok;
        slot_t e;
        int s = cfg_s(c);
        model_eval(c, st, bu, mb, fa, fb, ok);
        if (md_left[c] > 0) begin
            for (int k = s; k >= 3; k--) pipe[c][k] = pipe[c][k-1];
            pipe[c][2] = empty_slot();
            md_left[c]--;
            if (md_left[c] == 0) pipe[c][1].done = 1;
        end else begin
            for (int k = s; k >= 2; k--) pipe[c][k] = pipe[c][k-1];
            e = empty_slot();
            if (ok) begin
                e.v    = ID_WREG && (ID_DES != 0);
                e.des  = int'(ID_DES);
                e.ld   = ID_M2REG;
                e.md   = ID_MD;
                e.done = (cfg_ml(c) == 1);
                if (ID_MD && cfg_ml(c) > 1) md_left[c] = cfg_ml(c) - 1;
            end
            pipe[c][1] = e;
        end
    endtask

    function automatic void dut_get(input int c, output logic [31:0] st, bu, mb, fa, fb);
        case (c)
            0: begin st = 32'(stall0); bu = 32'(bubble0); mb = 32'(busy0); fa = 32'(fwda0); fb = 32'(fwdb0); end
            1: begin st = 32'(stall1); bu = 32'(bubble1); mb = 32'(busy1); fa = 32'(fwda1); fb = 32'(fwdb1); end
            default: begin st = 32'(stall2); bu = 32'(bubble2); mb = 32'(busy2); fa = 32'(fwda2); fb = 32'(fwdb2); end
        endcase
    endfunction

    // Inputs only change just after a rising edge, so the model advances at the falling
    // edge with the same inputs the DUT will sample at the next rising edge.
    initial begin
        logic [31:0] ds, db, dm, dfa, dfb, ms, mbu, mm, mfa, mfb;
        bit ok;
        model_reset();
        forever begin
            @(negedge CLK or posedge RST);
            if (RST) model_reset();
            if (!CLK) begin
                for (int c = 0; c < 3; c++) begin
                    dut_get(c, ds, db, dm, dfa, dfb);
                    model_eval(c, ms, mbu, mm, mfa, mfb, ok);
                    check($sformatf("c%0d stall", c), ds, ms);
                    check($sformatf("c%0d bubble", c), db, mbu);
                    check($sformatf("c%0d md_busy", c), dm, mm);
                    check($sformatf("c%0d fwda", c), dfa, mfa);
                    check($sformatf("c%0d fwdb", c), dfb, mfb);
                end
                if (!RST)
                    for (int c = 0; c < 3; c++) model_step(c);
            end
        end
    end

    task automatic op(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int des, input bit wr, input bit ld, input bit md, input bit fl);
        @(posedge CLK);
        #1;
        ID_VALID = v;  ID_RS = 5'(rs); ID_RT = 5'(rt); ID_USE_RS = urs; ID_USE_RT = urt;
        ID_DES = 5'(des); ID_WREG = wr; ID_M2REG = ld; ID_MD = md; FLUSH = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input int c, input int st, input int bu,
                       input int mb, input int fa, input int fb);
        logic [31:0] ds, db, dm, dfa, dfb, ms, mbu, mm, mfa, mfb;
        bit ok;
        #1;
        dut_get(c, ds, db, dm, dfa, dfb);
        model_eval(c, ms, mbu, mm, mfa, mfb, ok);
        check({name, " stall"}, ds, 32'(st));
        check({name, " bubble"}, db, 32'(bu));
        check({name, " md_busy"}, dm, 32'(mb));
        check({name, " fwda"}, dfa, 32'(fa));
        check({name, " fwdb"}, dfb, 32'(fb));
        check({name, " model_stall"}, ms, 32'(st));
        check({name, " model_fwda"}, mfa, 32'(fa));
        check({name, " model_fwdb"}, mfb, 32'(fb));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: run did not end, t=%0t", $time);
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        ID_VALID = 0; ID_RS = 0; ID_RT = 0; ID_USE_RS = 0; ID_USE_RT = 0;
        ID_DES = 0; ID_WREG = 0; ID_M2REG = 0; ID_MD = 0; FLUSH = 0;
        repeat (2) @(posedge CLK);
        #2;
        lit("reset", 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        lit("post_reset", 0, 0, 0, 0, 0, 0);

        // forwarding distance
        op(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);  lit("dist_prod", 0, 0, 0, 0, 0, 0);
        op(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);  lit("dist1", 0, 0, 0, 0, 1, 0);
        op(1, 3, 0, 1, 1, 8, 1, 0, 0, 0);  lit("dist2", 0, 0, 0, 0, 2, 0);
        op(1, 3, 0, 1, 0, 10, 1, 0, 0, 0); lit("dist3", 0, 0, 0, 0, 3, 0);
        op(1, 3, 0, 1, 0, 11, 1, 0, 0, 0); lit("dist4", 0, 0, 0, 0, 0, 0);
        lit("dist4_s4", 1, 0, 0, 0, 4, 0);
        idle(4);

        // load-use
        op(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);  lit("lw_issue", 0, 0, 0, 0, 0, 0);
        op(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);  lit("lu_stall", 0, 1, 1, 0, 0, 0);
        op(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);  lit("lu_fwd", 0, 0, 0, 0, 2, 2);
        idle(4);

        // youngest producer and register 0
        op(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
        op(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
        op(1, 7, 0, 1, 0, 11, 1, 0, 0, 0); lit("youngest", 0, 0, 0, 0, 1, 0);
        op(1, 1, 0, 1, 0, 0, 1, 0, 0, 0);  lit("r0_write", 0, 0, 0, 0, 0, 0);
        op(1, 0, 7, 1, 1, 12, 1, 0, 0, 0); lit("r0_read", 0, 0, 0, 0, 0, 3);
        idle(4);

        // multi-cycle op
        op(1, 1, 2, 1, 1, 9, 1, 0, 1, 0);  lit("mul_issue", 0, 0, 0, 0, 0, 0);
        op(1, 9, 0, 1, 0, 12, 1, 0, 0, 0); lit("md_busy1", 0, 1, 0, 1, 0, 0);
        lit("md_lat1", 2, 0, 0, 0, 1, 0);
        op(1, 9, 0, 1, 0, 12, 1, 0, 0, 0); lit("md_busy2", 0, 1, 0, 1, 0, 0);
        op(1, 9, 0, 1, 0, 12, 1, 0, 0, 0); lit("md_busy3", 0, 1, 0, 1, 0, 0);
        op(1, 9, 0, 1, 0, 12, 1, 0, 0, 0); lit("md_done", 0, 0, 0, 0, 1, 0);
        idle(4);

        // reset in the middle of a multi-cycle op
        op(1, 1, 2, 1, 1, 9, 1, 0, 1, 0);
        op(1, 9, 0, 1, 0, 12, 1, 0, 0, 0); lit("rst_busy1", 0, 1, 0, 1, 0, 0);
        op(1, 9, 0, 1, 0, 12, 1, 0, 0, 0); lit("rst_busy2", 0, 1, 0, 1, 0, 0);
        #1;
        RST = 1'b1;
        lit("rst_async", 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        lit("rst_after", 0, 0, 0, 0, 0, 0);
        idle(4);

        // deeper pipe, later load readiness
        op(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        op(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);  lit("s4_stall1", 1, 1, 1, 0, 0, 0);
        op(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);  lit("s4_stall2", 1, 1, 1, 0, 0, 0);
        op(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);  lit("s4_fwd", 1, 0, 0, 0, 3, 3);
        idle(5);
        op(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        op(1, 5, 5, 1, 1, 13, 1, 0, 0, 1); lit("s4_flush", 1, 0, 0, 0, 0, 0);
        op(1, 13, 0, 1, 0, 14, 1, 0, 0, 0); lit("s4_flush_bubble", 1, 0, 0, 0, 0, 0);
        idle(3);

        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
